multiplier_controller_taint_track: RTL and testbench

- Control FSM for the taint-tracked sequential multiplier. It sits directly upstream of the multiplier datapath.
- On a start request it sequences the datapath control strobes (mdld, mrld, rsclear, rsload, rsshr) one bit per iteration, then pulses done.
- Every strobe has a parallel taint output. The taint marks whether the strobe's value or timing depended on tainted information, namely start_t or a tainted multiplier bit read back from the datapath.

---
 rtl/multiplier_controller_taint_track.sv | 134 +++++++++++++
 tb/tb_multiplier_controller_taint_track.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/multiplier_controller_taint_track.sv
// Control FSM for the taint-tracked sequential multiplier.
// Sequences the datapath strobes one multiplier bit per iteration and carries
// a sticky taint bit that marks every strobe whose value or timing depended on
// a tainted start request or a tainted multiplier bit.
module multiplier_controller_taint_track #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             start_t,
  input  logic [WIDTH-1:0] multiplierReg,
  input  logic [WIDTH-1:0] multiplierReg_t,
  output logic             mdld,
  output logic             mdld_t,
  output logic             mrld,
  output logic             mrld_t,
  output logic             rsclear,
  output logic             rsclear_t,
  output logic             rsload,
  output logic             rsload_t,
  output logic             rsshr,
  output logic             rsshr_t,
  output logic             busy,
  output logic             done,
  output logic             done_t
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TEST,
    ADD,
    SHIFT,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic             ctrl_t_q, ctrl_t_d;
  logic             taint_d;

  // Next-state, bit counter and sticky taint; start is only looked at in IDLE.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    ctrl_t_d  = ctrl_t_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = LOAD;
          ctrl_t_d = start_t;
        end
      end
      LOAD: begin
        bit_idx_d = '0;
        state_d   = TEST;
      end
      TEST: begin
        ctrl_t_d = ctrl_t_q | multiplierReg_t[bit_idx_q];
        state_d  = multiplierReg[bit_idx_q] ? ADD : SHIFT;
      end
      ADD: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        if (bit_idx_q == LAST_IDX) begin
          bit_idx_d = '0;
          state_d   = DONE;
        end else begin
          bit_idx_d = bit_idx_q + 1'b1;
          state_d   = TEST;
        end
      end
      DONE: begin
        ctrl_t_d = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        bit_idx_d = '0;
        ctrl_t_d  = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // Taint is reported in every non-IDLE state, even when the strobe is low,
  // because the strobe's timing depends on the tainted information too.
  assign taint_d = (state_d != IDLE) && ctrl_t_d;

  // State registers plus outputs registered from the next-state decode, so the
  // outputs track the current state exactly with no input-to-output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
      ctrl_t_q  <= 1'b0;
      mdld      <= 1'b0;
      mrld      <= 1'b0;
      rsclear   <= 1'b0;
      rsload    <= 1'b0;
      rsshr     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mdld_t    <= 1'b0;
      mrld_t    <= 1'b0;
      rsclear_t <= 1'b0;
      rsload_t  <= 1'b0;
      rsshr_t   <= 1'b0;
      done_t    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      ctrl_t_q  <= ctrl_t_d;
      mdld      <= (state_d == LOAD);
      mrld      <= (state_d == LOAD);
      rsclear   <= (state_d == LOAD);
      rsload    <= (state_d == ADD);
      rsshr     <= (state_d == SHIFT);
      busy      <= (state_d != IDLE);
      done      <= (state_d == DONE);
      mdld_t    <= taint_d;
      mrld_t    <= taint_d;
      rsclear_t <= taint_d;
      rsload_t  <= taint_d;
      rsshr_t   <= taint_d;
      done_t    <= taint_d;
    end
  end

endmodule

// File: tb/tb_multiplier_controller_taint_track.sv
// Self-checking bench for multiplier_controller_taint_track.
// A reference model expands each operation into its expected per-cycle list of
// strobes and taint, which is compared against the DUT one cycle at a time.
module tb_multiplier_controller_taint_track;

  localparam int W = 4;

  typedef struct {
    logic [6:0] strobes;   // {busy, mdld, mrld, rsclear, rsload, rsshr, done}
    logic       taint;
  } cycle_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         start_t = 1'b0;
  logic [W-1:0] multiplierReg = '0;
  logic [W-1:0] multiplierReg_t = '0;
  logic mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t;
  logic rsload, rsload_t, rsshr, rsshr_t, busy, done, done_t;

  int checkCount = 0;
  int failCount = 0;
  int doneCount = 0;
  int opCount = 0;

  multiplier_controller_taint_track #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_t(start_t),
    .multiplierReg(multiplierReg), .multiplierReg_t(multiplierReg_t),
    .mdld(mdld), .mdld_t(mdld_t), .mrld(mrld), .mrld_t(mrld_t),
    .rsclear(rsclear), .rsclear_t(rsclear_t),
    .rsload(rsload), .rsload_t(rsload_t), .rsshr(rsshr), .rsshr_t(rsshr_t),
    .busy(busy), .done(done), .done_t(done_t)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [6:0] obsStrobes();
    return {busy, mdld, mrld, rsclear, rsload, rsshr, done};
  endfunction

  function automatic logic [6:0] obsTaints();
    return {1'b0, mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t, done_t};
  endfunction

  task automatic checkOutput(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: one LOAD, then per bit a TEST, an ADD when the bit is set, and a
  // SHIFT, then DONE. Taint starts at start_t and absorbs each bit's taint once
  // that bit has been tested.
  task automatic buildModel(input logic [W-1:0] mr, input logic [W-1:0] mt,
                            input logic st, output cycle_t q[$]);
    logic t;
    q = {};
    t = st;
    q.push_back('{7'b1111000, t});
    for (int b = 0; b < W; b++) begin
      q.push_back('{7'b1000000, t});
      t = t | mt[b];
      if (mr[b]) q.push_back('{7'b1000100, t});
      q.push_back('{7'b1000010, t});
    end
    q.push_back('{7'b1000001, t});
  endtask

  // Must be called at a falling edge while the DUT is in IDLE. keep leaves start
  // high for a back-to-back operation; pulseAt injects a start pulse while busy.
  task automatic applyStimulus(input string tag, input logic [W-1:0] mr, input logic [W-1:0] mt,
                               input logic st, input bit keep, input int pulseAt);
    cycle_t q[$];
    buildModel(mr, mt, st, q);
    multiplierReg   = mr;
    multiplierReg_t = mt;
    start           = 1'b1;
    start_t         = st;
    opCount++;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s.c%0d.strobe", tag, i + 1), obsStrobes(), q[i].strobes);
      checkOutput($sformatf("%s.c%0d.taint", tag, i + 1), obsTaints(), {1'b0, {6{q[i].taint}}});
      if (done === 1'b1) doneCount++;
      if (i == 0 && !keep) start = 1'b0;
      if (i == pulseAt) begin
        start   = 1'b1;
        start_t = ~st;
      end else if (i == pulseAt + 1) begin
        start   = keep;
        start_t = st;
      end
    end
    @(negedge clk);
    checkOutput({tag, ".idle.strobe"}, obsStrobes(), 7'b0);
    checkOutput({tag, ".idle.taint"}, obsTaints(), 7'b0);
  endtask

  initial begin
    logic [W-1:0] rmr, rmt;
    logic         rst;
    int           pa;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset.strobe", obsStrobes(), 7'b0);
    checkOutput("reset.taint", obsTaints(), 7'b0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postreset.idle", obsStrobes(), 7'b0);

    // Directed operations from the test plan.
    applyStimulus("mr0101", 4'b0101, 4'b0000, 1'b0, 1'b0, -10);
    applyStimulus("mr0000", 4'b0000, 4'b0000, 1'b0, 1'b0, -10);
    applyStimulus("mr1111", 4'b1111, 4'b0000, 1'b0, 1'b0, -10);
    applyStimulus("taintMr", 4'b0101, 4'b0100, 1'b0, 1'b0, -10);
    applyStimulus("taintStart", 4'b0011, 4'b0000, 1'b1, 1'b0, -10);
    applyStimulus("cleanAfter", 4'b0011, 4'b0000, 1'b0, 1'b0, -10);
    applyStimulus("busyPulse", 4'b1010, 4'b0000, 1'b0, 1'b0, 3);

    // start held high: exactly one IDLE cycle between back-to-back operations.
    applyStimulus("hold1", 4'b0110, 4'b0000, 1'b1, 1'b1, -10);
    applyStimulus("hold2", 4'b1001, 4'b0001, 1'b0, 1'b0, -10);

    // Asynchronous reset in the middle of an ADD.
    multiplierReg   = 4'b0101;
    multiplierReg_t = 4'b0000;
    start           = 1'b1;
    start_t         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midAdd.strobe", obsStrobes(), 7'b1000100);
    rst_n = 1'b0;
    #1;
    checkOutput("midAdd.reset.strobe", obsStrobes(), 7'b0);
    checkOutput("midAdd.reset.taint", obsTaints(), 7'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midAdd.release.idle", obsStrobes(), 7'b0);
    applyStimulus("afterReset", 4'b0101, 4'b0000, 1'b0, 1'b0, -10);

    // Randomized operations.
    for (int k = 0; k < 8; k++) begin
      rmr = W'($urandom_range(0, (1 << W) - 1));
      rmt = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, (1 << W) - 1)) : '0;
      rst = 1'($urandom_range(0, 1));
      pa  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : -10;
      applyStimulus($sformatf("rand%0d", k), rmr, rmt, rst, 1'b0, pa);
    end

    checkOutput("doneCount", 7'(doneCount), 7'(opCount));

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
